// File: rtl/ascon_state_bank.sv
// rtl/ascon_state_bank.sv - multi-context ASCON state storage with masked write modes and bypassed registered read
//
// Holds NB_CTX independent ASCON states of NB_WORDS x WORD_W bits so several
// computations can share one permutation core.
//
// Ports:
//   clock_i      rising-edge clock
//   resetb_i     asynchronous active-low reset
//   wr_en_i      write request
//   wr_ctx_i     write target context
//   wr_mode_i    00 load, 01 XOR, 10 clear, 11 no-op
//   wr_mask_i    per-word write enable, bit k = word k
//   wr_data_i    write data, word k at [k*WORD_W +: WORD_W]
//   rd_en_i      read request
//   rd_ctx_i     read context
//   rd_data_o    registered read data (post-write view of the context)
//   rd_valid_o   one-cycle pulse per accepted read
//   ctx_valid_o  per-context live-state flag
//   err_o        sticky out-of-range access flag
module ascon_state_bank #(
    parameter int NB_WORDS = 5,
    parameter int WORD_W   = 64,
    parameter int NB_CTX   = 4,
    parameter int CTX_W    = (NB_CTX > 1) ? $clog2(NB_CTX) : 1
) (
    input  logic                       clock_i,
    input  logic                       resetb_i,
    input  logic                       wr_en_i,
    input  logic [CTX_W-1:0]           wr_ctx_i,
    input  logic [1:0]                 wr_mode_i,
    input  logic [NB_WORDS-1:0]        wr_mask_i,
    input  logic [NB_WORDS*WORD_W-1:0] wr_data_i,
    input  logic                       rd_en_i,
    input  logic [CTX_W-1:0]           rd_ctx_i,
    output logic [NB_WORDS*WORD_W-1:0] rd_data_o,
    output logic                       rd_valid_o,
    output logic [NB_CTX-1:0]          ctx_valid_o,
    output logic                       err_o
);

    localparam logic [1:0]  MODE_LOAD = 2'b00;
    localparam logic [1:0]  MODE_XOR  = 2'b01;
    localparam logic [1:0]  MODE_CLR  = 2'b10;
    localparam int unsigned NB_CTX_U  = NB_CTX;

    logic [WORD_W-1:0]           mem_q [NB_CTX][NB_WORDS];
    logic [WORD_W-1:0]           mem_d [NB_CTX][NB_WORDS];
    logic [NB_CTX-1:0]           valid_q, valid_d;
    logic                        err_q, err_d;
    logic [NB_WORDS*WORD_W-1:0]  rd_data_q, rd_data_d;
    logic                        rd_valid_q, rd_valid_d;

    logic [31:0] wr_idx;
    logic [31:0] rd_idx;
    logic        wr_in_range;
    logic        rd_in_range;

    // Widen the indices so non-power-of-two context counts compare cleanly.
    assign wr_idx      = 32'(wr_ctx_i);
    assign rd_idx      = 32'(rd_ctx_i);
    assign wr_in_range = (wr_idx < NB_CTX_U);
    assign rd_in_range = (rd_idx < NB_CTX_U);

    always_comb begin
        mem_d      = mem_q;
        valid_d    = valid_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if ((wr_en_i && !wr_in_range) || (rd_en_i && !rd_in_range)) begin
            err_d = 1'b1;
        end

        // An all-zero mask or the no-op mode leaves storage and the valid flag alone.
        if (wr_en_i && wr_in_range && (wr_mask_i != '0) && (wr_mode_i != 2'b11)) begin
            for (int unsigned c = 0; c < NB_CTX_U; c++) begin
                if (wr_idx == c) begin
                    for (int k = 0; k < NB_WORDS; k++) begin
                        if (wr_mask_i[k]) begin
                            case (wr_mode_i)
                                MODE_LOAD: mem_d[c][k] = wr_data_i[k*WORD_W +: WORD_W];
                                MODE_XOR:  mem_d[c][k] = mem_q[c][k] ^ wr_data_i[k*WORD_W +: WORD_W];
                                MODE_CLR:  mem_d[c][k] = '0;
                                default:   mem_d[c][k] = mem_q[c][k];
                            endcase
                        end
                    end
                    if (wr_mode_i != MODE_CLR) begin
                        valid_d[c] = 1'b1;
                    end else if (&wr_mask_i) begin
                        valid_d[c] = 1'b0;
                    end
                end
            end
        end

        // Reading from mem_d gives the write-through view: masked words of a
        // same-cycle write to the same context are already updated.
        if (rd_en_i) begin
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
            if (rd_in_range) begin
                for (int unsigned c = 0; c < NB_CTX_U; c++) begin
                    if (rd_idx == c) begin
                        for (int k = 0; k < NB_WORDS; k++) begin
                            rd_data_d[k*WORD_W +: WORD_W] = mem_d[c][k];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            for (int c = 0; c < NB_CTX; c++) begin
                for (int k = 0; k < NB_WORDS; k++) begin
                    mem_q[c][k] <= '0;
                end
            end
            valid_q    <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign ctx_valid_o = valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ascon_state_bank.sv
// tb/tb_ascon_state_bank.sv - self-checking bench for ascon_state_bank
module tb_ascon_state_bank;

    localparam int NW = 5;
    localparam int WW = 64;
    localparam int DW = NW * WW;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    // 4-context instance
    logic          wr_en, rd_en;
    logic [1:0]    wr_ctx, rd_ctx, wr_mode;
    logic [NW-1:0] wr_mask;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_valid, err;
    logic [3:0]    ctx_valid;

    // 3-context instance for out-of-range coverage
    logic          b_wr_en, b_rd_en;
    logic [1:0]    b_wr_ctx, b_rd_ctx, b_wr_mode;
    logic [NW-1:0] b_wr_mask;
    logic [DW-1:0] b_wr_data, b_rd_data;
    logic          b_rd_valid, b_err;
    logic [2:0]    b_ctx_valid;

    ascon_state_bank #(.NB_WORDS(NW), .WORD_W(WW), .NB_CTX(4)) dut (
        .clock_i(clk), .resetb_i(resetb),
        .wr_en_i(wr_en), .wr_ctx_i(wr_ctx), .wr_mode_i(wr_mode), .wr_mask_i(wr_mask), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_ctx_i(rd_ctx),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .ctx_valid_o(ctx_valid), .err_o(err)
    );

    ascon_state_bank #(.NB_WORDS(NW), .WORD_W(WW), .NB_CTX(3)) dut3 (
        .clock_i(clk), .resetb_i(resetb),
        .wr_en_i(b_wr_en), .wr_ctx_i(b_wr_ctx), .wr_mode_i(b_wr_mode), .wr_mask_i(b_wr_mask), .wr_data_i(b_wr_data),
        .rd_en_i(b_rd_en), .rd_ctx_i(b_rd_ctx),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .ctx_valid_o(b_ctx_valid), .err_o(b_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a plain array of words per context plus a live flag.
    logic [WW-1:0] m [4][NW];
    logic [3:0]    mv;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < NW; k++) d[k*WW +: WW] = {$urandom, $urandom};
        return d;
    endfunction

    task automatic mdl_reset();
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < NW; k++) m[c][k] = '0;
        mv = '0;
    endtask

    task automatic mdl_write(input int c, input logic [1:0] mode, input logic [NW-1:0] mask, input logic [DW-1:0] d);
        for (int k = 0; k < NW; k++) begin
            if (mask[k]) begin
                if (mode == 2'd0) m[c][k] = d[k*WW +: WW];
                else if (mode == 2'd1) m[c][k] = m[c][k] ^ d[k*WW +: WW];
                else if (mode == 2'd2) m[c][k] = '0;
            end
        end
        if (mask != 0 && mode < 2) mv[c] = 1'b1;
        if (mode == 2'd2 && mask == 5'b11111) mv[c] = 1'b0;
    endtask

    function automatic logic [DW-1:0] mdl_read(input int c);
        logic [DW-1:0] d;
        for (int k = 0; k < NW; k++) d[k*WW +: WW] = m[c][k];
        return d;
    endfunction

    task automatic idle_inputs();
        wr_en = 0; wr_ctx = 0; wr_mode = 0; wr_mask = 0; wr_data = '0; rd_en = 0; rd_ctx = 0;
        b_wr_en = 0; b_wr_ctx = 0; b_wr_mode = 0; b_wr_mask = 0; b_wr_data = '0; b_rd_en = 0; b_rd_ctx = 0;
    endtask

    // Drive the 4-context instance for one cycle; return #1 after the edge.
    task automatic cyc(input logic we, input int wc, input logic [1:0] wm, input logic [NW-1:0] mk,
                       input logic [DW-1:0] wd, input logic re, input int rc);
        wr_en = we; wr_ctx = 2'(wc); wr_mode = wm; wr_mask = mk; wr_data = wd;
        rd_en = re; rd_ctx = 2'(rc);
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic load_ctx(input int c, input logic [DW-1:0] d);
        mdl_write(c, 2'd0, 5'b11111, d);
        cyc(1, c, 2'd0, 5'b11111, d, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            int c = $urandom_range(0, 3);
            cyc(1, c, 2'd0, 5'($urandom), rand_data(), 1, $urandom_range(0, 3));
        end
        b_wr_en = 1; b_wr_ctx = 2'd3; b_rd_en = 1;
        cyc(1, 1, 2'd0, 5'b11111, rand_data(), 1, 1);
        b_wr_en = 0; b_rd_en = 0;
        #2;
        wr_en = 1; wr_ctx = 2'($urandom); wr_mode = 2'($urandom); wr_mask = 5'($urandom);
        wr_data = rand_data(); rd_en = 1; rd_ctx = 2'($urandom);
        resetb = 1'b0;
        #1;
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (ctx_valid !== 4'b0) begin failures++; $display("FAIL reset_ctx_valid got=%b exp=0000", ctx_valid); end
        checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", b_err); end
        @(posedge clk);
        #4;
        idle_inputs();
        resetb = 1'b1;
        mdl_reset();
        @(posedge clk);
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL post_reset_no_result got=%b exp=0", rd_valid); end
        for (int c = 0; c < 4; c++) begin
            cyc(0, 0, 2'd3, 0, '0, 1, c);
            checks++;
            if (rd_data !== '0 || rd_valid !== 1'b1)
                begin failures++; $display("FAIL reset_read_ctx%0d got=%h valid=%b exp=0 valid=1", c, rd_data, rd_valid); end
        end
        checks++; if (ctx_valid !== 4'b0) begin failures++; $display("FAIL reset_ctx_valid_after got=%b exp=0000", ctx_valid); end
    endtask

    task automatic test_load_xor();
        logic [DW-1:0] d;
        logic [WW-1:0] pat;
        for (int k = 0; k < NW; k++) begin
            pat = {16{4'(k + 1)}};
            d[k*WW +: WW] = pat;
        end
        load_ctx(2, d);
        d = '0;
        d[WW-1:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        mdl_write(2, 2'd1, 5'b00001, d);
        cyc(1, 2, 2'd1, 5'b00001, d, 0, 0);
        cyc(0, 0, 2'd3, 0, '0, 1, 2);
        checks++;
        if (rd_data[WW-1:0] !== 64'hEEEE_EEEE_EEEE_EEEE)
            begin failures++; $display("FAIL load_xor_x0 got=%h exp=eeeeeeeeeeeeeeee", rd_data[WW-1:0]); end
        checks++;
        if (rd_data[DW-1:WW] !== {64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222})
            begin failures++; $display("FAIL load_xor_x1_x4 got=%h", rd_data[DW-1:WW]); end
        checks++; if (ctx_valid !== 4'b0100) begin failures++; $display("FAIL load_xor_ctx_valid got=%b exp=0100", ctx_valid); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] d;
        load_ctx(1, rand_data());
        d = '0;
        d[3*WW +: WW] = 64'h0F;
        mdl_write(1, 2'd1, 5'b01000, d);
        cyc(1, 1, 2'd1, 5'b01000, d, 1, 1);
        checks++;
        if (rd_data !== mdl_read(1) || rd_valid !== 1'b1)
            begin failures++; $display("FAIL bypass_read got=%h valid=%b exp=%h valid=1", rd_data, rd_valid, mdl_read(1)); end
        @(posedge clk);
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL bypass_valid_pulse got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== mdl_read(1)) begin failures++; $display("FAIL bypass_hold got=%h exp=%h", rd_data, mdl_read(1)); end
    endtask

    task automatic test_clear();
        load_ctx(0, rand_data());
        mdl_write(0, 2'd2, 5'b00110, '0);
        cyc(1, 0, 2'd2, 5'b00110, rand_data(), 1, 0);
        checks++;
        if (rd_data !== mdl_read(0) || rd_data[2*WW-1:WW] !== '0 || rd_data[3*WW-1:2*WW] !== '0)
            begin failures++; $display("FAIL partial_clear got=%h exp=%h", rd_data, mdl_read(0)); end
        checks++; if (ctx_valid[0] !== 1'b1) begin failures++; $display("FAIL partial_clear_valid got=%b exp=1", ctx_valid[0]); end
        mdl_write(0, 2'd0, 5'b00000, rand_data());
        cyc(1, 3, 2'd0, 5'b00000, rand_data(), 0, 0);
        checks++; if (ctx_valid[3] !== 1'b0) begin failures++; $display("FAIL zero_mask_valid got=%b exp=0", ctx_valid[3]); end
        mdl_write(0, 2'd2, 5'b11111, '0);
        cyc(1, 0, 2'd2, 5'b11111, rand_data(), 1, 0);
        checks++; if (ctx_valid[0] !== 1'b0) begin failures++; $display("FAIL full_clear_valid got=%b exp=0", ctx_valid[0]); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL full_clear_data got=%h exp=0", rd_data); end
    endtask

    task automatic b_cyc(input logic we, input int wc, input logic [DW-1:0] wd, input logic re, input int rc);
        b_wr_en = we; b_wr_ctx = 2'(wc); b_wr_mode = 2'd0; b_wr_mask = 5'b11111; b_wr_data = wd;
        b_rd_en = re; b_rd_ctx = 2'(rc);
        @(posedge clk);
        #1;
        b_wr_en = 0; b_rd_en = 0;
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] ref3 [3];
        for (int c = 0; c < 3; c++) begin
            ref3[c] = rand_data();
            b_cyc(1, c, ref3[c], 0, 0);
        end
        checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL oor_err_before got=%b exp=0", b_err); end
        b_cyc(1, 3, rand_data(), 1, 3);
        checks++;
        if (b_rd_data !== '0 || b_rd_valid !== 1'b1)
            begin failures++; $display("FAIL oor_read got=%h valid=%b exp=0 valid=1", b_rd_data, b_rd_valid); end
        checks++; if (b_err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", b_err); end
        checks++; if (b_ctx_valid !== 3'b111) begin failures++; $display("FAIL oor_ctx_valid got=%b exp=111", b_ctx_valid); end
        for (int c = 0; c < 3; c++) begin
            b_cyc(0, 0, '0, 1, c);
            checks++;
            if (b_rd_data !== ref3[c]) begin failures++; $display("FAIL oor_ctx%0d_kept got=%h exp=%h", c, b_rd_data, ref3[c]); end
        end
        checks++; if (b_err !== 1'b1) begin failures++; $display("FAIL oor_err_sticky got=%b exp=1", b_err); end
        #2 resetb = 1'b0;
        #1;
        checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL oor_err_reset got=%b exp=0", b_err); end
        #2 resetb = 1'b1;
        mdl_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_interleave();
        int gaps = 0;
        for (int i = 0; i < 200; i++) begin
            logic          we;
            int            wc, rc;
            logic [1:0]    wm;
            logic [NW-1:0] mk;
            logic [DW-1:0] wd;
            we = (i % 2 == 0) || ($urandom_range(0, 3) == 0);
            wc = $urandom_range(0, 3);
            rc = ($urandom_range(0, 2) == 0) ? wc : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) < 5) ? 2'd0 : 2'($urandom);
            mk = 5'($urandom);
            wd = rand_data();
            if (we) mdl_write(wc, wm, mk, wd);
            cyc(we, wc, wm, mk, wd, 1, rc);
            checks++;
            if (rd_data !== mdl_read(rc))
                begin failures++; $display("FAIL interleave_data cyc=%0d ctx=%0d got=%h exp=%h", i, rc, rd_data, mdl_read(rc)); end
            checks++;
            if (ctx_valid !== mv)
                begin failures++; $display("FAIL interleave_ctx_valid cyc=%0d got=%b exp=%b", i, ctx_valid, mv); end
            if (rd_valid !== 1'b1) gaps++;
        end
        checks++; if (gaps != 0) begin failures++; $display("FAIL interleave_valid_gaps got=%0d exp=0", gaps); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL interleave_err got=%b exp=0", err); end
    endtask

    initial begin
        idle_inputs();
        mdl_reset();
        #23 resetb = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_xor();
        test_bypass();
        test_clear();
        test_out_of_range();
        test_interleave();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascon_state_bank.md
# ascon_state_bank

Multi-context state storage for the ASCON datapath, replacing the single 320-bit state register so that up to NB_CTX independent ASCON computations can be interleaved on one permutation core. Each context holds NB_WORDS words of WORD_W bits. A context can be written through a masked write port in one of three modes: load, XOR-inject for absorb and key addition, or clear. A registered read port returns one context per cycle, with write-through bypass. The block sits between the permutation output and the permutation input multiplexer, under control of the ASCON FSM.

## Interface
Parameters:
- NB_WORDS, 5, number of words per context (x0..x4)
- WORD_W, 64, bits per word
- NB_CTX, 4, number of contexts, 1..16; CTX_W = max(1, clog2(NB_CTX))

Ports:
- clock_i  in  1  clock, rising edge
- resetb_i  in  1  reset, asynchronous, active-low
- wr_en_i  in  1  write request, one per cycle
- wr_ctx_i  in  CTX_W  target context of the write
- wr_mode_i  in  2  write mode: 00 load, 01 XOR, 10 clear, 11 no-op
- wr_mask_i  in  NB_WORDS  per-word write enable; bit k selects word k
- wr_data_i  in  NB_WORDS*WORD_W  write data; word k is at bits [k*WORD_W +: WORD_W], word 0 = x0
- rd_en_i  in  1  read request
- rd_ctx_i  in  CTX_W  context to read
- rd_data_o  out  NB_WORDS*WORD_W  registered read data, same packing as wr_data_i
- rd_valid_o  out  1  one-cycle pulse marking new rd_data_o
- ctx_valid_o  out  NB_CTX  bit c high means context c holds live state
- err_o  out  1  sticky; set by any access to a context index >= NB_CTX

## Operation
- Storage: NB_CTX × NB_WORDS flops of WORD_W bits. There is no RAM inference; all contexts are readable in any cycle.
- Write, when wr_en_i=1 and wr_ctx_i < NB_CTX. For each k with wr_mask_i[k]=1:
  - load: word ← wr_data_i word k
  - XOR: word ← word ^ wr_data_i word k
  - clear: word ← 0
  - no-op (11): no change
- Unmasked words are never modified.
- ctx_valid_o:
  - Set on any load or XOR write with a non-zero mask.
  - Cleared on a clear write with mask all ones.
  - A partial clear leaves the bit unchanged.
  - A write with an all-zero mask changes nothing, including ctx_valid_o.
- Read, when rd_en_i=1 and rd_ctx_i < NB_CTX: rd_data_o ← content of context rd_ctx_i as it stands after any write in the same cycle (write-through bypass). The bypass applies to masked words only.
- Out-of-range index:
  - A write is ignored.
  - A read returns all zeros with rd_valid_o=1.
  - Either access sets err_o.
  - If wr_ctx_i and rd_ctx_i are both out of range in the same cycle, err_o is set once (it is sticky).
- err_o is cleared only by reset.
- rd_data_o holds its last value when rd_en_i=0.
- Simultaneous read and write to different contexts are independent. The read returns the unmodified context.
- NB_CTX=1: the ctx inputs are 1 bit wide, and index 1 is out of range.

## Timing
- Reset, asynchronous, takes effect immediately on the falling edge of resetb_i:
  - all storage = 0
  - rd_data_o = 0
  - rd_valid_o = 0
  - ctx_valid_o = 0
  - err_o = 0
- Write latency: storage is updated at the rising edge that samples wr_en_i=1. A read of that context in the next cycle sees the new value.
- Read latency: 1 cycle. rd_en_i sampled at edge n gives rd_data_o and rd_valid_o=1 after edge n.
- rd_valid_o is high for exactly one cycle per accepted read.
- Back-to-back reads every cycle give one result per cycle.
- ctx_valid_o and err_o update at the same edge as the storage.
- Reset asserted mid-operation aborts any pending read. rd_valid_o falls immediately, and no result is produced after release.
- Throughput: one write and one read per cycle, no stalls, no backpressure.
- Critical path: mask/XOR on the write side, then the bypass mux and context mux feeding rd_data_o. No combinational path from any input to any output.

## Test plan
- Reset and idle: assert resetb_i mid-cycle with random inputs driven. Required: all outputs are 0 immediately. After release, a read of every context returns 0 and ctx_valid_o=0.
- Load then XOR, ctx 2:
  - Load x0..x4 = 0x1111…, 0x2222…, …, 0x5555… with mask 11111.
  - Then XOR wr_data word 0 = 0xFFFF_FFFF_FFFF_FFFF, mask 00001.
  - Read ctx 2. Required: x0 = 0xEEEE_EEEE_EEEE_EEEE, x1..x4 unchanged, ctx_valid_o = 0100.
- Same-cycle bypass: in one cycle, XOR ctx 1 word 3 with 0x0F and read ctx 1. Required: the next-cycle rd_data_o word 3 already includes the XOR, and rd_valid_o is high for one cycle.
- Partial and full clear:
  - Clear ctx 0 with mask 00110. Required: words 1 and 2 are 0, others kept, ctx_valid_o[0] stays 1.
  - Clear with mask 11111. Required: ctx_valid_o[0]=0.
- Out-of-range (NB_CTX=3): write and read ctx 3. Required: contexts 0–2 unchanged, rd_data_o=0, rd_valid_o=1, err_o=1 and held until reset.
- Interleaving: alternate writes and reads over 4 contexts every cycle for 200 random cycles against a scoreboard model. Required: zero mismatches and no rd_valid_o gaps.
